branch_predictor: RTL

//  Fetch-side bimodal branch predictor with direct-mapped BTB; the prediction end of the branch path.

---
 rtl/branch_predictor_pkg.sv | 26 ++
 rtl/branch_predictor_bp_table.sv | 67 ++++++
 rtl/branch_predictor.sv | 97 +++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictors: 2-bit saturating counter
// encodings and the counter update rule.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;

    // Saturating move towards taken/not-taken.
    function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
        ctr_t result;
        result = ctr;
        if (taken) begin
            if (ctr != ST) result = ctr_t'(ctr + 2'd1);
        end else begin
            if (ctr != SNT) result = ctr_t'(ctr - 2'd1);
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_predictor_bp_table.sv
// Direct-mapped predictor/BTB storage: one combinational lookup port and one
// read-modify-write update port that applies the bimodal training rule.
module bp_table
    import branch_predictor_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_BITS   = 6
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [IDX_BITS-1:0]            rd_idx,
    output logic                           rd_valid,
    output logic [DATA_WIDTH-IDX_BITS-3:0] rd_tag,
    output logic [DATA_WIDTH-1:0]          rd_target,
    output ctr_t                           rd_ctr,
    input  logic                           wr_en,
    input  logic [IDX_BITS-1:0]            wr_idx,
    input  logic [DATA_WIDTH-IDX_BITS-3:0] wr_tag,
    input  logic                           wr_taken,
    input  logic [DATA_WIDTH-1:0]          wr_target
);

    localparam int ENTRIES  = 2 ** IDX_BITS;
    localparam int TAG_BITS = DATA_WIDTH - IDX_BITS - 2;

    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [ENTRIES];
    ctr_t                  ctr_q    [ENTRIES];

    logic wr_hit;

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_target = target_q[rd_idx];
    assign rd_ctr    = ctr_q[rd_idx];

    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // A miss allocates the entry with a weak counter biased by this outcome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            if (wr_hit) begin
                ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
            end else begin
                ctr_q[wr_idx] <= wr_taken ? WT : WNT;
            end
        end
    end

    // Tags and targets are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx] <= wr_tag;
            if (wr_taken) begin
                target_q[wr_idx] <= wr_target;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side bimodal branch predictor with direct-mapped BTB, mispredict
// redirect and resolved-branch statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_BITS   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] lk_pc,
    output logic                  lk_taken,
    output logic [DATA_WIDTH-1:0] lk_target,
    input  logic                  up_valid,
    input  logic [DATA_WIDTH-1:0] up_pc,
    input  logic                  up_taken,
    input  logic [DATA_WIDTH-1:0] up_target,
    input  logic                  up_pred_taken,
    input  logic [DATA_WIDTH-1:0] up_pred_target,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
);

    localparam int TAG_BITS = DATA_WIDTH - IDX_BITS - 2;

    logic [IDX_BITS-1:0]   lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [IDX_BITS-1:0]   up_idx;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [DATA_WIDTH-1:0] rd_target;
    ctr_t                  rd_ctr;
    logic                  lk_hit;
    logic                  mp;

    assign lk_idx = lk_pc[IDX_BITS+1:2];
    assign lk_tag = lk_pc[DATA_WIDTH-1:IDX_BITS+2];
    assign up_idx = up_pc[IDX_BITS+1:2];
    assign up_tag = up_pc[DATA_WIDTH-1:IDX_BITS+2];

    bp_table #(
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_BITS  (IDX_BITS)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (lk_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_target(rd_target),
        .rd_ctr   (rd_ctr),
        .wr_en    (up_valid),
        .wr_idx   (up_idx),
        .wr_tag   (up_tag),
        .wr_taken (up_taken),
        .wr_target(up_target)
    );

    // Lookup sees the pre-update table when it shares an index with an update.
    assign lk_hit    = rd_valid && (rd_tag == lk_tag);
    assign lk_taken  = lk_hit && rd_ctr[1];
    assign lk_target = lk_taken ? rd_target : lk_pc + DATA_WIDTH'(4);

    assign mp = up_valid && ((up_taken != up_pred_taken) ||
                             (up_taken && (up_target != up_pred_target)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= mp;
            if (mp) begin
                redirect_pc <= up_taken ? up_target : up_pc + DATA_WIDTH'(4);
            end
        end
    end

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (up_valid && (stat_branches != 32'hFFFF_FFFF)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mp && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end

endmodule
